// File: rtl/sha_arbiter_if.sv
// Bus bundle between the requesters, sha_arbiter and the shared sha_core.
// The slave modport is the arbiter's view; master is the requester/core side.
interface sha_arbiter_if #(
    parameter int N_REQ = 4
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0]     req;
    logic [N_REQ*512-1:0] msg;
    logic [N_REQ-1:0]     gnt;
    logic [N_REQ-1:0]     done;
    logic [255:0]         digest;
    logic                 err;
    logic                 busy;
    logic [ID_W-1:0]      owner;
    logic                 core_clr;
    logic                 core_write_en;
    logic [511:0]         core_message;
    logic [255:0]         core_hashvalue;
    logic                 core_valid;

    modport slave (
        input  req, msg, core_hashvalue, core_valid,
        output gnt, done, digest, err, busy, owner,
               core_clr, core_write_en, core_message
    );

    modport master (
        output req, msg, core_hashvalue, core_valid,
        input  gnt, done, digest, err, busy, owner,
               core_clr, core_write_en, core_message
    );
endinterface

// File: rtl/sha_arbiter.sv
// sha_arbiter: round-robin sequencer sharing one sha_core among N_REQ requesters.
// Defining SHA_ARB_WDOG_EN adds a watchdog that aborts a job whose core never reports valid.
module sha_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic         clk,
    input  logic         clr,
    sha_arbiter_if.slave bus
);
    localparam int              ID_W     = $clog2(N_REQ);
    localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ID_W-1:0]    r_last, w_last_nxt;
    logic [ID_W-1:0]    r_owner, w_owner_nxt;
    logic [N_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [N_REQ-1:0]   r_done, w_done_nxt;
    logic [255:0]       r_digest, w_digest_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_core_clr, w_core_clr_nxt;
    logic               r_core_wen, w_core_wen_nxt;
    logic [511:0]       r_core_msg, w_core_msg_nxt;
    logic               w_err_nxt;
    logic [ID_W-1:0]    w_win, w_cand;
    logic               w_win_vld;
    int                 w_idx;
    logic [511:0]       w_blk [N_REQ];

`ifdef SHA_ARB_WDOG_EN
    localparam logic [6:0] WDOG_LIMIT = 7'd72;
    logic [6:0] r_wdog, w_wdog_nxt;
    logic       r_err;
`endif

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_blk
        assign w_blk[gi] = bus.msg[gi*512 +: 512];
    end

    // Round-robin pick: scanning downward from last+N leaves last+1 as the final, winning candidate.
    always_comb begin
        w_win     = r_last;
        w_win_vld = 1'b0;
        w_idx     = 0;
        w_cand    = r_last;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx  = (int'(r_last) + k) % N_REQ;
            w_cand = ID_W'(w_idx);
            if (bus.req[w_cand]) begin
                w_win     = w_cand;
                w_win_vld = 1'b1;
            end else begin
                w_win     = w_win;
                w_win_vld = w_win_vld;
            end
        end
    end

    // Next state and next values of every registered output.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_gnt_nxt      = {N_REQ{1'b0}};
        w_done_nxt     = {N_REQ{1'b0}};
        w_digest_nxt   = r_digest;
        w_core_clr_nxt = r_core_clr;
        w_core_wen_nxt = 1'b0;
        w_core_msg_nxt = r_core_msg;
        w_err_nxt      = 1'b0;
`ifdef SHA_ARB_WDOG_EN
        w_wdog_nxt     = r_wdog;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt        = S_LOAD;
                    w_owner_nxt        = w_win;
                    w_gnt_nxt[w_win]   = 1'b1;
                    w_core_msg_nxt     = w_blk[w_win];
                    w_core_clr_nxt     = 1'b1;
                    w_core_wen_nxt     = 1'b1;
                end else begin
                    w_core_clr_nxt     = 1'b0;
                end
            end
            S_LOAD: begin
                w_state_nxt = S_RUN;
`ifdef SHA_ARB_WDOG_EN
                w_wdog_nxt  = 7'd0;
`endif
            end
            S_RUN: begin
                if (bus.core_valid) begin
                    w_state_nxt         = S_IDLE;
                    w_digest_nxt        = bus.core_hashvalue;
                    w_done_nxt[r_owner] = 1'b1;
                    w_last_nxt          = r_owner;
                    w_core_clr_nxt      = 1'b0;
                end
`ifdef SHA_ARB_WDOG_EN
                else if (r_wdog == WDOG_LIMIT) begin
                    w_state_nxt         = S_IDLE;
                    w_digest_nxt        = 256'd0;
                    w_done_nxt[r_owner] = 1'b1;
                    w_err_nxt           = 1'b1;
                    w_last_nxt          = r_owner;
                    w_core_clr_nxt      = 1'b0;
                end else begin
                    w_wdog_nxt = r_wdog + 7'd1;
                end
`else
                else begin
                    w_state_nxt = S_RUN;
                end
`endif
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_core_clr_nxt = 1'b0;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers; clearing drops every output and holds the core in clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state    <= S_IDLE;
            r_last     <= LAST_RST;
            r_owner    <= {ID_W{1'b0}};
            r_gnt      <= {N_REQ{1'b0}};
            r_done     <= {N_REQ{1'b0}};
            r_digest   <= 256'd0;
            r_busy     <= 1'b0;
            r_core_clr <= 1'b0;
            r_core_wen <= 1'b0;
            r_core_msg <= 512'd0;
`ifdef SHA_ARB_WDOG_EN
            r_wdog     <= 7'd0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_last     <= w_last_nxt;
            r_owner    <= w_owner_nxt;
            r_gnt      <= w_gnt_nxt;
            r_done     <= w_done_nxt;
            r_digest   <= w_digest_nxt;
            r_busy     <= w_busy_nxt;
            r_core_clr <= w_core_clr_nxt;
            r_core_wen <= w_core_wen_nxt;
            r_core_msg <= w_core_msg_nxt;
`ifdef SHA_ARB_WDOG_EN
            r_wdog     <= w_wdog_nxt;
            r_err      <= w_err_nxt;
`endif
        end
    end

    assign bus.gnt           = r_gnt;
    assign bus.done          = r_done;
    assign bus.digest        = r_digest;
    assign bus.busy          = r_busy;
    assign bus.owner         = r_owner;
    assign bus.core_clr      = r_core_clr;
    assign bus.core_write_en = r_core_wen;
    assign bus.core_message  = r_core_msg;
`ifdef SHA_ARB_WDOG_EN
    assign bus.err           = r_err;
`else
    assign bus.err           = 1'b0 & w_err_nxt;
`endif
endmodule

// File: doc/sha_arbiter.md
# sha_arbiter

Round-robin arbiter and sequencer that shares one `sha_core` single-block SHA-256 engine among `N_REQ` requesters. It accepts one 512-bit pre-padded block from the winning requester and holds the core in clear while idle. It releases the core and issues the one-cycle `write_en` load aligned to the core's round counter, then waits for the core's `valid` pulse. It returns the 256-bit digest with a per-requester done pulse. It sits between the bus-side request ports and the `sha_core` instance.

## Interface
- `N_REQ`, 4: number of requesters, legal range 2..8.
- `ID_W`, `$clog2(N_REQ)`: owner-id width; derived, not overridden.
- `clk` in 1: system clock; all logic on the rising edge.
- `clr` in 1: asynchronous, active-low reset.
- `req` in N_REQ: per-requester request; held high until the matching `gnt` pulse.
- `msg` in N_REQ*512: requester i block at `[i*512 +: 512]`; stable while `req[i]` is high.
- `gnt` out N_REQ: one-hot, one-cycle pulse; block captured.
- `done` out N_REQ: one-hot, one-cycle pulse; `digest` valid for that owner.
- `digest` out 256: last result; held until the next `done`.
- `err` out 1: one-cycle pulse with `done` on watchdog abort. Tied 0 without the macro.
- `busy` out 1: high in every state except IDLE.
- `owner` out ID_W: index of the current or last granted requester.
- `core_clr` out 1: drives the `sha_core` `clr` (active-low); registered.
- `core_write_en` out 1: drives `sha_core` `write_en`; registered.
- `core_message` out 512: drives `sha_core` `message`; holds the captured block.
- `core_hashvalue` in 256: from `sha_core`.
- `core_valid` in 1: from `sha_core`; one-cycle pulse.

## Operation
- State IDLE:
  - `core_clr`=0, which holds the core counter at 0.
  - If any `req` is high, select the winner by round-robin. Search starts at `last+1` mod N_REQ.
  - Latch the winner's `msg` into `core_message`, set `owner`, pulse `gnt[owner]`, set `core_clr`=1 and `core_write_en`=1, then go to LOAD.
- State LOAD, exactly 1 cycle:
  - The core leaves reset; on the next edge the core buffer loads and its counter goes 0→1.
  - Drop `core_write_en` and go to RUN.
- State RUN:
  - Wait for `core_valid`=1.
  - On that edge: `digest`<=`core_hashvalue`, pulse `done[owner]`, set `last`<=`owner`, set `core_clr`<=0, go to IDLE.
- Round-robin:
  - `last` resets to N_REQ-1, so requester 0 wins first.
  - A requester that was just served has the lowest priority in the next arbitration.
- A `req` dropped before its `gnt` is a withdrawal; no state change.
- `req` changes during LOAD or RUN are ignored until IDLE.
- `core_message` is unchanged from the grant edge until the next grant.
- `core_valid` seen in IDLE or LOAD is spurious and ignored.
- Reset, including mid-operation: every output goes to 0 (`core_clr`=0 clears the core), the state goes to IDLE, and `last`=N_REQ-1. A job in flight is lost; no `done` pulse is issued.

## Timing
- Grant edge G: `gnt` high in cycle G..G+1.
- `core_write_en` high for exactly one cycle, G..G+1.
- Core buffer load at G+1.
- `core_valid` high in cycle G+67..G+68.
- `digest` and `done` update at edge G+68; `done` high for cycle G+68..G+69.
- Next grant is possible at edge G+69 at the earliest, giving 69 cycles per block.
- `busy` high from G to G+68.
- `gnt` and `done` are never asserted in the same cycle.

## Configuration
- `SHA_ARB_WDOG_EN` defined:
  - A 7-bit watchdog counter runs in RUN.
  - If `core_valid` has not arrived 72 cycles after entering RUN: `digest`<=0, pulse `done[owner]` and `err` together, set `core_clr`<=0, go to IDLE.
  - `last` is updated as for a normal completion.
- Not defined:
  - No watchdog; RUN waits indefinitely.
  - `err` is constant 0.

## Test plan
- Requester 0, block "abc" (`0x61626380…00000018`), grant at edge G: `gnt`=0001 at G+1; `core_write_en` one cycle; `done`=0001 at G+69 with `digest`=`ba7816bf…f20015ad`.
- All four `req` held high continuously: grant order 0,1,2,3,0; grants spaced 69 cycles apart; each digest matches its requester's block.
- `req[2]` pulsed for 1 cycle while busy: no grant to 2. `req[2]` then held: granted next; order follows the rotation from `last`.
- `clr` low at G+30, then released: all outputs 0, no `done`. A new request is served normally with the correct digest.
- With `SHA_ARB_WDOG_EN`, core model suppresses `valid`: `done[owner]`=1 and `err`=1 in the same cycle, 73 cycles after entering RUN; `digest`=0; next requester is then served. Without the macro: `busy` stays 1 and `err` stays 0.
